instr_serial_loader: RTL and testbench

Upstream front-end for the ALU top level. It turns the raw board inputs `instr_load_en` (push-button) and `instruction_in` (slide switch) into a clean 4-bit opcode. It synchronises and debounces both inputs, then shifts in one opcode bit per debounced press, LSB first. It raises `opcode_valid` once all four bits are captured and holds the opcode until an instruction reset.

---
 rtl/instr_serial_loader.sv | 118 +++++++++++
 tb/tb_instr_serial_loader.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/instr_serial_loader.sv
// instr_serial_loader: synchronises and debounces the board load button and
// opcode switch, then shifts one opcode bit per debounced press, LSB first.
module instr_serial_loader #(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned CNT_W           = 16
) (
    input  logic       clk,
    input  logic       reset_all_n,
    input  logic       instr_load_en,
    input  logic       instruction_in,
    input  logic       reset_instr,
    output logic [3:0] opcode,
    output logic [2:0] bit_count,
    output logic       opcode_valid,
    output logic       opcode_strobe
);

    localparam logic [CNT_W-1:0] CntMax = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Two-flop synchronisers
    logic load_s1_q, load_s2_q;
    logic din_s1_q, din_s2_q;
    logic rst_s1_q, rst_s2_q;

    // Debouncer state
    logic             db_level_q, db_level_d;
    logic [CNT_W-1:0] db_cnt_q, db_cnt_d;
    logic             capture;

    // Opcode shift state
    logic [3:0] opcode_q, opcode_d;
    logic [2:0] bit_count_q, bit_count_d;
    logic       opcode_valid_q, opcode_valid_d;
    logic       opcode_strobe_q, opcode_strobe_d;

    // Synchronise the three asynchronous inputs; the clear idles high
    always_ff @(posedge clk or negedge reset_all_n) begin
        if (!reset_all_n) begin
            load_s1_q <= 1'b0;
            load_s2_q <= 1'b0;
            din_s1_q  <= 1'b0;
            din_s2_q  <= 1'b0;
            rst_s1_q  <= 1'b1;
            rst_s2_q  <= 1'b1;
        end else begin
            load_s1_q <= instr_load_en;
            load_s2_q <= load_s1_q;
            din_s1_q  <= instruction_in;
            din_s2_q  <= din_s1_q;
            rst_s1_q  <= reset_instr;
            rst_s2_q  <= rst_s1_q;
        end
    end

    // Debounce: level flips only after DEBOUNCE_CYCLES consecutive differing samples
    always_comb begin
        db_level_d = db_level_q;
        db_cnt_d   = db_cnt_q;
        capture    = 1'b0;
        if (load_s2_q == db_level_q) begin
            db_cnt_d = '0;
        end else if (db_cnt_q == CntMax) begin
            db_level_d = ~db_level_q;
            db_cnt_d   = '0;
            capture    = ~db_level_q;  // only the 0->1 transition loads a bit
        end else begin
            db_cnt_d = db_cnt_q + CNT_W'(1);
        end
    end

    // Debouncer registers
    always_ff @(posedge clk or negedge reset_all_n) begin
        if (!reset_all_n) begin
            db_level_q <= 1'b0;
            db_cnt_q   <= '0;
        end else begin
            db_level_q <= db_level_d;
            db_cnt_q   <= db_cnt_d;
        end
    end

    // Opcode capture; an instruction clear overrides a coincident capture
    always_comb begin
        opcode_d        = opcode_q;
        bit_count_d     = bit_count_q;
        opcode_strobe_d = 1'b0;
        if (!rst_s2_q) begin
            opcode_d    = 4'b0000;
            bit_count_d = 3'd0;
        end else if (capture && (bit_count_q != 3'd4)) begin
            opcode_d[bit_count_q[1:0]] = din_s2_q;
            bit_count_d                = bit_count_q + 3'd1;
            opcode_strobe_d            = (bit_count_q == 3'd3);
        end
        opcode_valid_d = (bit_count_d == 3'd4);
    end

    // Opcode output registers
    always_ff @(posedge clk or negedge reset_all_n) begin
        if (!reset_all_n) begin
            opcode_q        <= 4'b0000;
            bit_count_q     <= 3'd0;
            opcode_valid_q  <= 1'b0;
            opcode_strobe_q <= 1'b0;
        end else begin
            opcode_q        <= opcode_d;
            bit_count_q     <= bit_count_d;
            opcode_valid_q  <= opcode_valid_d;
            opcode_strobe_q <= opcode_strobe_d;
        end
    end

    assign opcode        = opcode_q;
    assign bit_count     = bit_count_q;
    assign opcode_valid  = opcode_valid_q;
    assign opcode_strobe = opcode_strobe_q;

endmodule

// File: tb/tb_instr_serial_loader.sv
// Directed bench for instr_serial_loader with D=16 and a 20 ns clock.
module tb_instr_serial_loader;

    logic       clk = 1'b0;
    logic       reset_all_n = 1'b1;
    logic       instr_load_en = 1'b0;
    logic       instruction_in = 1'b0;
    logic       reset_instr = 1'b1;
    logic [3:0] opcode;
    logic [2:0] bit_count;
    logic       opcode_valid;
    logic       opcode_strobe;

    int n_checks = 0;
    int n_pass   = 0;
    int strobe_cnt = 0;

    instr_serial_loader #(
        .DEBOUNCE_CYCLES(16),
        .CNT_W          (16)
    ) dut (
        .clk           (clk),
        .reset_all_n   (reset_all_n),
        .instr_load_en (instr_load_en),
        .instruction_in(instruction_in),
        .reset_instr   (reset_instr),
        .opcode        (opcode),
        .bit_count     (bit_count),
        .opcode_valid  (opcode_valid),
        .opcode_strobe (opcode_strobe)
    );

    always #10 clk = ~clk;

    // Count strobe cycles away from the active edge
    always @(negedge clk) if (opcode_strobe === 1'b1) strobe_cnt++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Advance n rising edges, then settle 1 ns past the edge
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // 50-cycle press then 50-cycle gap; checks the count just before and at edge 18
    task automatic press(input logic b, input int cnt_before, input int cnt_after);
        instruction_in = b;
        step(5);
        instr_load_en = 1'b1;
        step(17);
        check("cnt_edge17", 32'(bit_count), 32'(cnt_before));
        step(1);
        check("cnt_edge18", 32'(bit_count), 32'(cnt_after));
        check("strobe_edge18", 32'(opcode_strobe),
              32'((cnt_before == 3) && (cnt_after == 4)));
        step(1);
        check("strobe_edge19", 32'(opcode_strobe), 32'd0);
        step(31);
        instr_load_en = 1'b0;
        step(50);
    endtask

    task automatic clear_instr(input int n);
        reset_instr = 1'b0;
        step(n);
        reset_instr = 1'b1;
        step(4);
    endtask

    initial begin
        int s0;
        // Reset, checked before any clock edge and while inputs are random
        #1 reset_all_n = 1'b0;
        #1;
        check("rst_opcode", 32'(opcode), 32'd0);
        check("rst_count", 32'(bit_count), 32'd0);
        check("rst_valid", 32'(opcode_valid), 32'd0);
        check("rst_strobe", 32'(opcode_strobe), 32'd0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            instr_load_en  = 1'($urandom_range(1));
            instruction_in = 1'($urandom_range(1));
            reset_instr    = 1'($urandom_range(1));
            #2;
            check("rst_hold", {opcode, bit_count, opcode_valid, opcode_strobe}, 32'd0);
        end
        @(posedge clk);
        #1;
        instr_load_en  = 1'b0;
        instruction_in = 1'b0;
        reset_instr    = 1'b1;
        reset_all_n    = 1'b1;
        step(5);

        // Serial load of 4'b1011
        s0 = strobe_cnt;
        press(1'b1, 0, 1);
        press(1'b1, 1, 2);
        press(1'b0, 2, 3);
        press(1'b1, 3, 4);
        check("load_opcode", 32'(opcode), 32'hb);
        check("load_valid", 32'(opcode_valid), 32'd1);
        check("load_strobes", 32'(strobe_cnt - s0), 32'd1);

        // Overflow: 4'b1100 then two extra presses
        clear_instr(10);
        check("clr_count", 32'(bit_count), 32'd0);
        check("clr_valid", 32'(opcode_valid), 32'd0);
        press(1'b0, 0, 1);
        press(1'b0, 1, 2);
        press(1'b1, 2, 3);
        press(1'b1, 3, 4);
        s0 = strobe_cnt;
        press(1'b1, 4, 4);
        press(1'b1, 4, 4);
        check("ovf_opcode", 32'(opcode), 32'hc);
        check("ovf_valid", 32'(opcode_valid), 32'd1);
        check("ovf_strobes", 32'(strobe_cnt - s0), 32'd0);

        // Instruction clear after two bits, then load 4'b0010
        clear_instr(10);
        press(1'b1, 0, 1);
        press(1'b1, 1, 2);
        reset_instr = 1'b0;
        step(5);
        check("mid_clr", {opcode, bit_count, opcode_valid, opcode_strobe}, 32'd0);
        step(25);
        reset_instr = 1'b1;
        step(4);
        check("post_clr_count", 32'(bit_count), 32'd0);
        press(1'b0, 0, 1);
        press(1'b1, 1, 2);
        press(1'b0, 2, 3);
        press(1'b0, 3, 4);
        check("clr_load_opcode", 32'(opcode), 32'h2);

        // Clear lands on the capture edge (edge 18); press stays held past it
        clear_instr(10);
        instruction_in = 1'b1;
        step(5);
        instr_load_en = 1'b1;
        step(15);
        reset_instr = 1'b0;
        step(1);
        reset_instr = 1'b1;
        step(2);
        check("coinc_count", 32'(bit_count), 32'd0);
        step(32);
        instr_load_en = 1'b0;
        step(50);
        check("coinc_final", 32'(bit_count), 32'd0);
        check("coinc_opcode", 32'(opcode), 32'd0);

        // Bounce rejection: glitches then one clean press
        for (int i = 0; i < 5; i++) begin
            instr_load_en = 1'b1;
            step(3);
            instr_load_en = 1'b0;
            step(2);
        end
        instr_load_en = 1'b1;
        step(40);
        instr_load_en = 1'b0;
        step(50);
        check("bounce_count", 32'(bit_count), 32'd1);
        check("bounce_opcode", 32'(opcode), 32'h1);
        // 15-cycle pulse is shorter than D
        instr_load_en = 1'b1;
        step(15);
        instr_load_en = 1'b0;
        step(50);
        check("short_pulse", 32'(bit_count), 32'd1);

        // Async reset while button held mid-debounce
        instruction_in = 1'b0;
        instr_load_en  = 1'b1;
        step(8);
        reset_all_n = 1'b0;
        #1;
        check("async_count", 32'(bit_count), 32'd0);
        check("async_opcode", 32'(opcode), 32'd0);
        step(3);
        reset_all_n   = 1'b1;
        instr_load_en = 1'b0;
        step(20);
        press(1'b1, 0, 1);
        check("async_final_opcode", 32'(opcode), 32'h1);
        check("async_final_count", 32'(bit_count), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Global watchdog
    initial begin
        #5ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule
